frame_payload_scheduler: RTL

Receive-side payload scheduler between the frame synchronizer and the Hamming(7,4) decoder. Once the synchronizer reports lock, it tracks frame alignment, skips the 8-bit frame head, and cuts the 56 payload bits of every 64-bit frame into eight 7-bit codewords. Codewords go to the decoder through a 2-entry valid/ready buffer. The block also keeps frame, head-miss and overflow statistics.

---
 rtl/frame_pkg.sv | 16 +
 rtl/frame_payload_scheduler_if.sv | 13 +
 rtl/cw_fifo.sv | 73 +++++++
 rtl/frame_payload_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared constants and FSM encoding for the receive-side frame payload scheduler.
package frame_pkg;

  localparam logic [7:0]  FRAME_HEAD = 8'b01111110;
  localparam int unsigned FRAME_LEN  = 64;
  localparam int unsigned HEAD_LEN   = 8;
  localparam int unsigned CW_LEN     = 7;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HEAD,
    PAYLOAD,
    HEAD
  } state_e;

endpackage

// File: rtl/frame_payload_scheduler_if.sv
// Valid/ready codeword channel from the payload scheduler to the Hamming decoder.
interface frame_payload_scheduler_if #(
    parameter int unsigned Width = frame_pkg::CW_LEN
);

    logic [Width-1:0] cw_data;
    logic             cw_valid;
    logic             cw_ready;

    modport master (output cw_data, output cw_valid, input cw_ready);
    modport slave  (input cw_data, input cw_valid, output cw_ready);

endinterface

// File: rtl/cw_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop happens on the
// same edge.
module cw_fifo #(
    parameter int unsigned Width = 7,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o     = (cnt_q == CntW'(Depth));
    assign empty_o    = (cnt_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || pop_i);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_payload_scheduler.sv
// Tracks frame alignment after sync lock, strips frame heads and slices the payload into
// codewords for the decoder, keeping frame / head-miss / overflow statistics.
module frame_payload_scheduler #(
    parameter int unsigned FRAME_LEN = frame_pkg::FRAME_LEN,
    parameter int unsigned HEAD_LEN  = frame_pkg::HEAD_LEN,
    parameter int unsigned CW_LEN    = frame_pkg::CW_LEN,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                       clk_out,
    input  logic                       rst,
    input  logic                       data_in,
    input  logic                       sync_locked,
    input  logic                       head_match,
    frame_payload_scheduler_if.master  cw_if,
    output logic                       frame_done,
    output logic [15:0]                frame_cnt,
    output logic [7:0]                 head_miss_cnt,
    output logic                       overflow
);

    import frame_pkg::*;

    localparam int unsigned PayLen = FRAME_LEN - HEAD_LEN;
    localparam int unsigned BitW   = $clog2(PayLen);
    localparam int unsigned HdW    = $clog2(HEAD_LEN);
    localparam int unsigned CwW    = $clog2(CW_LEN);

    localparam logic [BitW-1:0] LastBit = BitW'(PayLen - 1);
    localparam logic [HdW-1:0]  LastHd  = HdW'(HEAD_LEN - 1);
    localparam logic [CwW-1:0]  LastCw  = CwW'(CW_LEN - 1);

    state_e              state_q, state_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [HdW-1:0]      hd_cnt_q, hd_cnt_d;
    logic [CwW-1:0]      cw_cnt_q, cw_cnt_d;
    logic [CW_LEN-1:0]   shift_q, shift_d;
    logic                frame_done_q, frame_done_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [7:0]          head_miss_cnt_q, head_miss_cnt_d;
    logic                overflow_q, overflow_d;

    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [CW_LEN-1:0]   fifo_head;
    logic [CW_LEN-1:0]   new_cw;

    assign new_cw = {shift_q[CW_LEN-2:0], data_in};

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        hd_cnt_d        = hd_cnt_q;
        cw_cnt_d        = cw_cnt_q;
        shift_d         = shift_q;
        frame_done_d    = 1'b0;
        frame_cnt_d     = frame_cnt_q;
        head_miss_cnt_d = head_miss_cnt_q;
        push            = 1'b0;

        // Losing lock abandons the frame in progress; the buffer is left alone.
        if (!sync_locked) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            hd_cnt_d  = '0;
            cw_cnt_d  = '0;
            shift_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_HEAD;
                WAIT_HEAD: begin
                    if (head_match) begin
                        state_d   = PAYLOAD;
                        bit_cnt_d = '0;
                        cw_cnt_d  = '0;
                    end
                end
                PAYLOAD: begin
                    shift_d   = new_cw;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (cw_cnt_q == LastCw) begin
                        push     = 1'b1;
                        cw_cnt_d = '0;
                    end else begin
                        cw_cnt_d = cw_cnt_q + 1'b1;
                    end
                    if (bit_cnt_q == LastBit) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        hd_cnt_d     = '0;
                        state_d      = HEAD;
                    end
                end
                HEAD: begin
                    hd_cnt_d = hd_cnt_q + 1'b1;
                    if (hd_cnt_q == LastHd) begin
                        // Flywheel: a missing head is counted but alignment is kept.
                        state_d   = PAYLOAD;
                        bit_cnt_d = '0;
                        cw_cnt_d  = '0;
                        if (!head_match && head_miss_cnt_q != 8'hFF) begin
                            head_miss_cnt_d = head_miss_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop        = !empty && cw_if.cw_ready;
    assign overflow_d = overflow_q | (push && full && !pop);

    cw_fifo #(
        .Width (CW_LEN),
        .Depth (BUF_DEPTH)
    ) u_cw_fifo (
        .clk_i       (clk_out),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (new_cw),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            hd_cnt_q        <= '0;
            cw_cnt_q        <= '0;
            shift_q         <= '0;
            frame_done_q    <= 1'b0;
            frame_cnt_q     <= '0;
            head_miss_cnt_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            hd_cnt_q        <= hd_cnt_d;
            cw_cnt_q        <= cw_cnt_d;
            shift_q         <= shift_d;
            frame_done_q    <= frame_done_d;
            frame_cnt_q     <= frame_cnt_d;
            head_miss_cnt_q <= head_miss_cnt_d;
            overflow_q      <= overflow_d;
        end
    end

    assign cw_if.cw_data  = fifo_head;
    assign cw_if.cw_valid = !empty;
    assign frame_done     = frame_done_q;
    assign frame_cnt      = frame_cnt_q;
    assign head_miss_cnt  = head_miss_cnt_q;
    assign overflow       = overflow_q;

endmodule
